scan_loader: RTL and testbench
==============================

SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter WORD_W, default 8: width of a configuration word accepted and read back.
REQ-002 Parameter CHAIN_LEN, default 64: total scan-chain length in bits; SHALL be a multiple of WORD_W.
REQ-003 Parameter DIV, default 1: clk cycles per shift_clk half-period; SHALL be >= 1.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 start  input  1: one-cycle request to begin a full chain load session.
REQ-007 in_data  input  WORD_W: configuration word, MSB shifted first.
REQ-008 in_valid  input  1: in_data valid.
REQ-009 in_ready  output  1: loader accepts in_data this cycle.
REQ-010 shift_clk  output  1: scan clock to the chain; chain cells capture on its rising edge.
REQ-011 shift_o  output  1: serial data to the chain head (shift_i of first cell).
REQ-012 shift_i  input  1: serial data from the chain tail (shift_o of last cell).
REQ-013 out_data  output  WORD_W: readback word of previous chain contents, first-sampled bit in MSB.
REQ-014 out_valid  output  1: one-cycle strobe, out_data valid; no backpressure.
REQ-015 busy  output  1: session in progress (any state but IDLE).
REQ-016 done  output  1: one-cycle pulse when the session completes.

Function
REQ-017 FSM states: IDLE, WAIT_WORD, SHIFT_LO, SHIFT_HI, DONE.
REQ-018 IDLE: busy=0, in_ready=0; start=1 -> WAIT_WORD, clear bit counter; in_valid ignored.
REQ-019 WAIT_WORD: in_ready=1, shift_clk=0; in_valid&in_ready loads shift register with in_data, clears word-bit counter -> SHIFT_LO; without in_valid, stay, no shift_clk edges.
REQ-020 SHIFT_LO: shift_clk=0, shift_o=shift register MSB; lasts exactly DIV cycles -> SHIFT_HI.
REQ-021 On the last SHIFT_LO cycle shift_i SHALL be sampled into the readback register (value before the chain shifts).
REQ-022 SHIFT_HI: shift_clk=1, shift_o held stable; lasts exactly DIV cycles; on exit shift register shifts left by one, bit and word-bit counters increment.
REQ-023 SHIFT_HI exit: bit count == CHAIN_LEN -> DONE; else word-bit count == WORD_W -> WAIT_WORD; else -> SHIFT_LO.
REQ-024 On each word completion (incl. last) out_data = WORD_W sampled bits, out_valid=1 for exactly one cycle, coincident with first cycle of next state.
REQ-025 DONE: done=1 for one cycle, busy=1 -> IDLE; shift_clk=0.
REQ-026 Each bit takes exactly 2*DIV clk cycles; a full session produces exactly CHAIN_LEN shift_clk rising edges.
REQ-027 Word accepted at cycle k -> first shift_clk rise at cycle k+1+DIV.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 shift_clk and shift_o SHALL be driven directly from registers (glitch-free).

Reset
REQ-030 rst=1 at any clk edge -> IDLE next cycle, regardless of state, including mid-bit or mid-word.
REQ-031 Reset values: shift_clk=0, shift_o=0, in_ready=0, out_data=0, out_valid=0, busy=0, done=0; counters and shift/readback registers 0.
REQ-032 Reset mid-session SHALL NOT produce done or out_valid; chain contents are left as-is.
REQ-033 rst has priority over start and in_valid in the same cycle.

Verification (WORD_W=8, CHAIN_LEN=16, DIV=1 unless stated; chain modeled as 16-bit shift register on shift_clk rise)
REQ-034 Reset: assert rst 2 cycles -> all outputs 0, in_ready=0 until start.
REQ-035 Load 0xA5 then 0x3C into zeroed chain -> shift_o bit sequence 1010010100111100, 16 rising edges, out_data 0x00 twice, done one cycle after last SHIFT_HI; second session with 0xFF,0x00 reads back 0xA5, 0x3C.
REQ-036 in_valid withheld 5 cycles between words -> shift_clk low throughout gap, in_ready=1 throughout, still exactly 16 edges total.
REQ-037 start pulsed mid-session and in_valid=1 while IDLE -> no restart, no word consumed, session count of edges unchanged.
REQ-038 rst after 3rd rising edge -> next cycle shift_clk=0, busy=0, no done/out_valid; new start then completes normally.
REQ-039 DIV=3 -> shift_clk high and low each exactly 3 cycles; 96 cycles from first SHIFT_LO to DONE excluding WAIT_WORD cycles.

Source files
------------

// File: rtl/scan_loader.sv
// Serial scan-chain loader: shifts configuration words into a scan chain while
// capturing the previous chain contents for readback, one word at a time.
module scan_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int DIV       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift_clk,
  output logic              shift_o,
  input  logic              shift_i,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int DW = $clog2(DIV + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam int BW = $clog2(CHAIN_LEN + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [WW-1:0] WBIT_LAST = WW'(WORD_W - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CHAIN_LEN - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [WW-1:0] WBIT_ONE  = WW'(1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [WW-1:0]     wbit_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] rdback;

  // The chain head always sees the shift register MSB, straight from a flop.
  assign shift_o = shreg[WORD_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      shift_clk <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_cnt   <= '0;
      wbit_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rdback    <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_WAIT_WORD;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        S_WAIT_WORD: begin
          if (in_valid) begin
            shreg    <= in_data;
            wbit_cnt <= '0;
            div_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          if (div_cnt == DIV_LAST) begin
            // Sample the tail before the rising edge moves the chain.
            rdback    <= (rdback << 1) | WORD_W'(shift_i);
            div_cnt   <= '0;
            shift_clk <= 1'b1;
            state     <= S_SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        S_SHIFT_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            shift_clk <= 1'b0;
            shreg     <= shreg << 1;
            bit_cnt   <= bit_cnt + BIT_ONE;
            wbit_cnt  <= wbit_cnt + WBIT_ONE;
            if (wbit_cnt == WBIT_LAST) begin
              out_data  <= rdback;
              out_valid <= 1'b1;
            end
            if (bit_cnt == BIT_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (wbit_cnt == WBIT_LAST) begin
              state    <= S_WAIT_WORD;
              in_ready <= 1'b1;
            end else begin
              state <= S_SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: two instances (DIV=1 and DIV=3) on 16-bit modelled chains,
// checked every cycle against a timing model built from cycles-since-word-accept.
module tb_scan_loader;

  localparam int W = 8;
  localparam int L = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         st0, st1, iv0, iv1;
  logic [W-1:0] id0, id1;
  logic         rdy0, rdy1, sc0, sc1, so0, so1, ov0, ov1, bs0, bs1, dn0, dn1;
  logic [W-1:0] od0, od1;
  logic         si0, si1;

  logic [L-1:0] ch0 = '0;
  logic [L-1:0] ch1 = '0;
  int           ec0 = 0;
  int           ec1 = 0;

  // Chain cells capture the head bit on each shift_clk rise; the tail feeds back.
  always @(posedge sc0) begin ch0 <= {ch0[L-2:0], so0}; ec0 <= ec0 + 1; end
  always @(posedge sc1) begin ch1 <= {ch1[L-2:0], so1}; ec1 <= ec1 + 1; end
  assign si0 = ch0[L-1];
  assign si1 = ch1[L-1];

  scan_loader #(.WORD_W(W), .CHAIN_LEN(L), .DIV(1)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .in_data(id0), .in_valid(iv0),
    .in_ready(rdy0), .shift_clk(sc0), .shift_o(so0), .shift_i(si0),
    .out_data(od0), .out_valid(ov0), .busy(bs0), .done(dn0));

  scan_loader #(.WORD_W(W), .CHAIN_LEN(L), .DIV(3)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .in_data(id1), .in_valid(iv1),
    .in_ready(rdy1), .shift_clk(sc1), .shift_o(so1), .shift_i(si1),
    .out_data(od1), .out_valid(ov1), .busy(bs1), .done(dn1));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 idle, 1 waiting for a word, 2 shifting, 3 done cycle.
  int           ph[2];
  int           t[2];
  int           nb[2];
  int           ecs[2];
  int           runc[2];
  logic [W-1:0] wd[2];
  logic [L-1:0] snap[2];
  logic [L-1:0] wl[2];
  logic         eov[2];
  logic [W-1:0] eod[2];
  logic         rsd[2];
  logic [W-1:0] rbh[2][2];

  function automatic logic [13:0] outs(input int i);
    return (i == 0) ? {rdy0, sc0, so0, ov0, bs0, dn0, od0}
                    : {rdy1, sc1, so1, ov1, bs1, dn1, od1};
  endfunction

  function automatic logic [9:0] ins(input int i);
    return (i == 0) ? {st0, iv0, id0} : {st1, iv1, id1};
  endfunction

  function automatic logic [L-1:0] chain(input int i);
    return (i == 0) ? ch0 : ch1;
  endfunction

  function automatic int ecnt(input int i);
    return (i == 0) ? ec0 : ec1;
  endfunction

  function automatic int divof(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic s, input logic v, input logic [W-1:0] d);
    if (i == 0) begin st0 = s; iv0 = v; id0 = d; end
    else begin st1 = s; iv1 = v; id1 = d; end
  endtask

  task automatic model_step(input int i);
    logic s, v;
    logic [W-1:0] d;
    int dv;
    dv = divof(i);
    {s, v, d} = ins(i);
    eov[i] = 1'b0;
    rsd[i] = 1'b0;
    if (rst) begin
      ph[i]  = 0;
      rsd[i] = 1'b1;
    end else begin
      case (ph[i])
        0: if (s) begin
          ph[i] = 1; nb[i] = 0; runc[i] = 0; wl[i] = '0;
          snap[i] = chain(i); ecs[i] = ecnt(i);
        end
        1: if (v) begin
          ph[i] = 2; t[i] = 1; wd[i] = d; wl[i] = {wl[i][W-1:0], d};
        end
        2: if (t[i] == W * 2 * dv) begin
          eov[i] = 1'b1;
          eod[i] = (nb[i] == 0) ? snap[i][L-1:W] : snap[i][W-1:0];
          nb[i]  = nb[i] + W;
          ph[i]  = (nb[i] == L) ? 3 : 1;
        end else begin
          t[i] = t[i] + 1;
        end
        default: ph[i] = 0;
      endcase
    end
  endtask

  task automatic compare(input int i);
    logic [13:0] o;
    logic r, sc, so, ov, bs, dn, es;
    logic [W-1:0] od;
    int dv;
    dv = divof(i);
    o = outs(i);
    {r, sc, so, ov, bs, dn, od} = o;
    es = (ph[i] == 2) && ((((t[i] - 1) / dv) % 2) == 1);
    check(i, "busy", bs, ph[i] != 0);
    check(i, "in_ready", r, ph[i] == 1);
    check(i, "done", dn, ph[i] == 3);
    check(i, "shift_clk", sc, es);
    check(i, "out_valid", ov, eov[i]);
    if (eov[i]) begin
      check(i, "out_data", od, eod[i]);
      rbh[i][nb[i] / W - 1] = od;
    end
    if (rsd[i]) begin
      check(i, "reset out_data", od, 0);
      check(i, "reset shift_o", so, 0);
    end
    if (ph[i] == 2) check(i, "shift_o", so, wd[i][7 - (t[i] - 1) / (2 * dv)]);
    if (bs && !r && !dn) runc[i]++;
    if (ph[i] == 3) begin
      check(i, "chain contents", chain(i), wl[i]);
      check(i, "edge count", ecnt(i) - ecs[i], L);
      check(i, "shift cycles", runc[i], (i == 0) ? 32 : 96);
    end
  endtask

  task automatic wait_for(input int i, input int b, input string nm);
    logic [13:0] o;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      o = outs(i);
      if (o[b]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check(i, nm, ok, 1);
  endtask

  task automatic session(input int i, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input int gap, input bit poke);
    logic [W-1:0] ws[2];
    ws[0] = w0;
    ws[1] = w1;
    if (poke) begin
      drive(i, 1'b0, 1'b1, 8'h5A);
      repeat (2) @(negedge clk);
    end
    drive(i, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(i, 1'b0, 1'b0, '0);
    for (int w = 0; w < 2; w++) begin
      wait_for(i, 13, "wait in_ready");
      if (w == 1) repeat (gap) @(negedge clk);
      drive(i, 1'b0, 1'b1, ws[w]);
      @(negedge clk);
      drive(i, 1'b0, 1'b0, '0);
      if (poke && w == 0) begin
        repeat (3) @(negedge clk);
        drive(i, 1'b1, 1'b0, '0);
        @(negedge clk);
        drive(i, 1'b0, 1'b0, '0);
      end
    end
    wait_for(i, 8, "wait done");
    @(negedge clk);
  endtask

  task automatic rand_session(input int i);
    logic [13:0] o;
    bit ok;
    repeat ($urandom_range(0, 3)) begin
      drive(i, 1'b0, 1'($urandom % 2), 8'($urandom));
      @(negedge clk);
    end
    drive(i, 1'b1, 1'b0, '0);
    @(negedge clk);
    ok = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      o = outs(i);
      if (o[8]) begin ok = 1'b1; break; end
      drive(i, 1'(($urandom % 16) == 0), 1'(($urandom % 3) == 0), 8'($urandom));
      @(negedge clk);
    end
    drive(i, 1'b0, 1'b0, '0);
    check(i, "random session done", ok, 1);
    @(negedge clk);
  endtask

  task automatic reset_mid_session();
    int base;
    logic [13:0] o;
    base = ec0;
    drive(0, 1'b1, 1'b0, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0);
    wait_for(0, 13, "wait in_ready");
    drive(0, 1'b0, 1'b1, 8'hC3);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 100; k++) begin
      if (ec0 - base >= 3) break;
      @(negedge clk);
    end
    check(0, "third edge reached", ec0 - base, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = outs(0);
    check(0, "mid reset busy", o[9], 0);
    check(0, "mid reset shift_clk", o[12], 0);
    check(0, "mid reset done", o[8], 0);
    check(0, "mid reset out_valid", o[10], 0);
    repeat (2) @(negedge clk);
    session(0, 8'h12, 8'h34, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    fork
      forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) compare(i);
      end
    join_none

    repeat (2) @(negedge clk);
    check(0, "reset outputs", outs(0), 0);
    check(1, "reset outputs", outs(1), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      session(i, 8'hA5, 8'h3C, 0, 1'b0);
      check(i, "first readback word", rbh[i][0], 8'h00);
      check(i, "second readback word", rbh[i][1], 8'h00);
      check(i, "chain after A5 3C", chain(i), 16'hA53C);
      session(i, 8'hFF, 8'h00, 5, 1'b1);
      check(i, "readback A5", rbh[i][0], 8'hA5);
      check(i, "readback 3C", rbh[i][1], 8'h3C);
      check(i, "chain after FF 00", chain(i), 16'hFF00);
    end

    reset_mid_session();
    check(0, "chain after 12 34", ch0, 16'h1234);

    for (int n = 0; n < 24; n++) rand_session(n % 2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
